// File: rtl/crc16_pkg.sv
// Shared SD constants and the CRC16 bit-step function.
// Benches and RTL both build on crc16_step.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY_SD = 16'h1021;
  localparam logic [15:0] CRC16_INIT_SD = 16'h0000;

  // One MSB-first bit of CRC-16 (x^16 implicit in poly).
  function automatic logic [15:0] crc16_step(
    input logic [15:0] r,
    input logic        b,
    input logic [15:0] poly = CRC16_POLY_SD
  );
    logic fb;
    fb = b ^ r[15];
    return {r[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16.sv
// Serial CRC16 for one SD DAT line, one bit per enabled edge.
// Output comes straight from the register.
module crc16
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY_SD,
  parameter logic [15:0] INIT = CRC16_INIT_SD
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        bitval,
  input  logic        enable,
  output logic [15:0] crc
);

  always_ff @(posedge sd_clk) begin
    if (!rst) begin
      crc <= INIT;
    end else if (enable) begin
      crc <= crc16_step(crc, bitval, POLY);
    end
  end

endmodule

// File: tb/tb_crc16.sv
// Scoreboard bench for crc16 against a polynomial
// long-division reference model.
module tb_crc16;

  logic        sd_clk = 1'b0;
  logic        rst    = 1'b0;
  logic        bitval = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] crc;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q[$];
  string       nm_q[$];
  bit          msg[$];

  crc16 dut (
    .sd_clk (sd_clk),
    .rst    (rst),
    .bitval (bitval),
    .enable (enable),
    .crc    (crc)
  );

  always #5 sd_clk = ~sd_clk;

  // Remainder of M(x)*x^16 divided by G(x), G = 0x11021.
  function automatic logic [15:0] ref_crc();
    logic [16:0] rem;
    bit          b;
    rem = '0;
    for (int i = 0; i < msg.size() + 16; i++) begin
      b   = (i < msg.size()) ? msg[i] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic cyc(input logic r, input logic e, input logic b);
    rst    = r;
    enable = e;
    bitval = b;
    @(posedge sd_clk);
    #1;
  endtask

  task automatic expect_crc(input logic [15:0] v, input string nm);
    exp_q.push_back(v);
    nm_q.push_back(nm);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'($urandom), 1'($urandom));
    msg.delete();
  endtask

  task automatic shift(input logic b);
    cyc(1'b1, 1'b1, b);
    msg.push_back(b);
  endtask

  task automatic shift_byte(input logic [7:0] x);
    for (int i = 7; i >= 0; i--) shift(x[i]);
  endtask

  task automatic hold_cycles(input int n, input string nm);
    logic [15:0] h;
    h = ref_crc();
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'($urandom));
      expect_crc(h, nm);
    end
  endtask

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge sd_clk) begin
    logic [15:0] e;
    string       n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      tests++;
      if (crc !== e) begin
        fails++;
        $display("FAIL %s: crc=%h expected=%h", n, crc, e);
      end
    end
  end

  initial begin
    string s;
    logic [15:0] keep;
    s = "123456789";

    cyc(1'b0, 1'b0, 1'b0);
    do_reset();
    expect_crc(16'h0000, "reset");

    shift(1'b1);
    expect_crc(16'h1021, "single_one");
    expect_crc(ref_crc(), "single_one_model");

    do_reset();
    for (int i = 0; i < 16; i++) shift(1'b0);
    expect_crc(16'h0000, "sixteen_zeros");

    shift_byte(8'hA5);
    cyc(1'b0, 1'b1, 1'b1);
    msg.delete();
    expect_crc(16'h0000, "reset_with_enable");

    do_reset();
    for (int i = 0; i < 9; i++) begin
      shift_byte(s[i]);
      expect_crc(ref_crc(), "ascii_prefix");
    end
    expect_crc(16'h31C3, "ascii_vector");

    do_reset();
    for (int i = 0; i < 512; i++) shift_byte(8'hFF);
    expect_crc(16'h7FA1, "sd_ff_block");
    expect_crc(ref_crc(), "sd_ff_model");

    do_reset();
    for (int i = 0; i < 9; i++) begin
      shift_byte(s[i]);
      if (i == 4) hold_cycles(10, "hold");
    end
    expect_crc(16'h31C3, "ascii_after_hold");

    do_reset();
    for (int i = 0; i < 40; i++) shift(1'($urandom));
    keep = ref_crc();
    cyc(1'b0, 1'b1, 1'($urandom));
    msg.delete();
    expect_crc(16'h0000, "mid_reset");
    for (int i = 0; i < 9; i++) shift_byte(s[i]);
    expect_crc(16'h31C3, "ascii_after_mid_reset");

    for (int m = 0; m < 20; m++) begin
      int len;
      do_reset();
      len = $urandom_range(64, 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          hold_cycles(1, "rand_hold");
        end else begin
          shift(1'($urandom));
          expect_crc(ref_crc(), "rand_msg");
        end
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sd_clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    @(posedge sd_clk);
    #1;
    if (keep === 16'hxxxx) $display("note: undefined prefix crc");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
